multi_ch_cal_datapath: RTL and testbench
========================================

Name: multi_ch_cal_datapath

Overview:
Parametrised, multi-channel successor to the single-channel offset/gain calibration datapath. Each raw A2D sample carries a channel tag and is corrected as res = sat((sat(a2d + offset[ch])) * gain[ch]). The per-channel offset and gain coefficients live in an internal register file that is written by a config port. The block sits between the A2D sequencer and the downstream consumer, with valid/ready handshakes on both sides and a small FSM that sequences the add and multiply stages.

Parameters:
DATA_W, 12, width of a2d, offset, gain and res.
CHANNELS, 4, number of calibration channels (>=1).
CH_W, $clog2(CHANNELS) (min 1), width of the channel index ports. Derived; not overridden.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  a raw sample is presented.
in_ready  out  1  block can accept a sample.
in_ch  in  CH_W  channel of the presented sample.
a2d  in  DATA_W  raw unsigned sample.
cfg_we  in  1  coefficient write strobe.
cfg_sel  in  1  0 = offset, 1 = gain.
cfg_ch  in  CH_W  channel being written.
cfg_wdata  in  DATA_W  coefficient value.
out_valid  out  1  res is valid.
out_ready  in  1  consumer accepts res.
out_ch  out  CH_W  channel tag of res.
res  out  DATA_W  calibrated result.
out_sat  out  1  add or multiply saturated for this result.
out_err  out  1  in_ch >= CHANNELS for this result.

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE; in_ready=1; out_valid=0; res=0; out_ch=0; out_sat=0; out_err=0; every offset[ch]=0; every gain[ch]=2^(DATA_W-1), which is unity. Reset mid-operation discards the in-flight sample.
- Number formats:
  - offset: signed two's complement.
  - gain: unsigned 1.(DATA_W-1) fixed point; 0x800 = 1.0, 0xC00 = 1.5, 0x600 = 0.75 for DATA_W=12.
- Add stage: sum = a2d + sign-extended offset, computed at DATA_W+2 bits.
  - sum < 0 clamps to 0.
  - sum > 2^DATA_W-1 clamps to 2^DATA_W-1.
  - Either clamp sets the sticky sat bit for this sample.
- Multiply stage: prod = tmp * gain at 2*DATA_W bits, then shifted right by DATA_W-1 (truncate, no rounding).
  - Any nonzero bit above DATA_W after the shift clamps the result to 2^DATA_W-1 and sets sat.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, the accept edge captures a2d and in_ch, and snapshots offset[in_ch] and gain[in_ch]. Next state ADD.
  - ADD: in_ready=0. Registers the clamped sum into tmp. Next state MUL.
  - MUL: in_ready=0. Registers res, out_sat and out_ch. Sets out_valid. Next state HOLD.
  - HOLD: out_valid=1; res, out_ch, out_sat and out_err are stable. If out_ready=1 at an edge, out_valid clears and the state returns to IDLE.
- Latency and throughput:
  - Accept at edge N gives out_valid=1 after edge N+2.
  - Minimum 4 cycles per sample: in_ready is low from the edge after acceptance until HOLD completes.
- Coefficient writes:
  - cfg_we at an edge updates the selected register at that edge.
  - Writes are allowed in every FSM state.
  - An in-flight sample uses its snapshot. A write in the same cycle as acceptance to the same channel is not seen by that sample; the old value is used.
  - Writes with cfg_ch >= CHANNELS are ignored.
- Out-of-range in_ch (>= CHANNELS): the sample is processed with offset 0 and unity gain. out_err=1 with that result; otherwise out_err=0.
- out_sat and out_err are cleared on each new acceptance.

Decomposition:
- Package cal_pkg:
  - state_t enum {IDLE, ADD, MUL, HOLD}.
  - Function unity_gain(width).
  - Saturating helper functions sat_add_u and sat_mul_fx, parametrised by width.
- Sub-module cal_coef_rf: per-channel offset/gain register file with reset values, a write port and a combinational read port at in_ch. Out-of-range handling lives there.
- The FSM and arithmetic stay in the top module.

Test Plan:
- After reset, ch0: offset=0xFFE. Sample a2d=0x89A -> res=0x898, out_sat=0. Then set gain[0]=0xC00 and resend -> res=0xCE4.
- ch1: offset=0, gain=0xC00, a2d=0xABC -> res=0xFFF, out_sat=1 (multiply overflow). ch2: offset=0x555, gain=unity, a2d=0xABC -> res=0xFFF, out_sat=1 (add overflow).
- ch3: offset=0xFFE, a2d=0x001 -> res=0x000, out_sat=1 (underflow). Same channel with a2d=0x003 -> res=0x001, out_sat=0.
- ch0: offset=0x555, gain=0x600, a2d=0x456 -> res=0x740 (gain < 1, truncation).
- Back-pressure: hold out_ready=0 for 5 cycles -> out_valid, res and out_ch stay stable and in_ready=0. Rewrite gain for that channel during the stall -> the held result is unchanged. The next sample uses the new gain.
- Snapshot, reset and out-of-range:
  - Write gain[ch1] in the same cycle as accepting a ch1 sample -> the old gain is used.
  - Assert rst_n=0 while in MUL -> out_valid=0 and in_ready=1 after that edge, and all coefficients are back to defaults.
  - With CHANNELS=3 and in_ch=3 -> unity result with out_err=1.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared types and saturating arithmetic helpers for the multi-channel calibration datapath.
// Helpers work on MAX_W-wide vectors with a runtime width, so callers need DATA_W < MAX_W.
package cal_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [MAX_W-1:0] val;
    } sat_res_t;

    function automatic logic [MAX_W-1:0] unity_gain(input int width);
        logic [MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << (width - 1);
    endfunction

    // Unsigned sample plus a width-bit two's complement offset, clamped to [0, 2^width-1].
    function automatic sat_res_t sat_add_u(input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] off,
                                           input int               width);
        logic signed [MAX_W+1:0] a_x;
        logic signed [MAX_W+1:0] off_x;
        logic signed [MAX_W+1:0] sum;
        logic        [MAX_W-1:0] one;
        logic        [MAX_W-1:0] mask;
        sat_res_t                r;
        one    = '0;
        one[0] = 1'b1;
        mask   = (one << width) - one;
        a_x    = signed'({2'b00, a});
        off_x  = signed'({2'b00, off}) <<< (MAX_W + 2 - width);
        off_x  = off_x >>> (MAX_W + 2 - width);
        sum    = a_x + off_x;
        r.sat  = 1'b0;
        r.val  = sum[MAX_W-1:0];
        if (sum[MAX_W+1]) begin
            r.sat = 1'b1;
            r.val = '0;
        end else if (sum > signed'({2'b00, mask})) begin
            r.sat = 1'b1;
            r.val = mask;
        end
        return r;
    endfunction

    // Unsigned sample times a 1.(width-1) gain, truncated, clamped to 2^width-1.
    function automatic sat_res_t sat_mul_fx(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] gain,
                                            input int               width);
        logic [2*MAX_W-1:0] prod;
        logic [MAX_W-1:0]   one;
        logic [MAX_W-1:0]   mask;
        sat_res_t           r;
        one    = '0;
        one[0] = 1'b1;
        mask   = (one << width) - one;
        prod   = ({{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, gain}) >> (width - 1);
        r.sat  = 1'b0;
        r.val  = prod[MAX_W-1:0];
        if ((prod >> width) != '0) begin
            r.sat = 1'b1;
            r.val = mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/cal_coef_rf.sv
// Per-channel offset/gain coefficient store: one write port, one combinational read port.
// Out-of-range reads return offset 0 / unity gain with an error flag; out-of-range writes are dropped.
module cal_coef_rf
    import cal_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_off,
    output logic [DATA_W-1:0] rd_gain,
    output logic              rd_err
);

    localparam logic [DATA_W-1:0] UNITY    = DATA_W'(unity_gain(DATA_W));
    localparam logic [CH_W:0]     CH_LIMIT = CHANNELS[CH_W:0];

    logic [DATA_W-1:0] offset_q [CHANNELS];
    logic [DATA_W-1:0] offset_d [CHANNELS];
    logic [DATA_W-1:0] gain_q   [CHANNELS];
    logic [DATA_W-1:0] gain_d   [CHANNELS];
    logic              rd_in_range;
    logic              wr_in_range;

    assign rd_in_range = ({1'b0, rd_ch} < CH_LIMIT);
    assign wr_in_range = ({1'b0, cfg_ch} < CH_LIMIT);

    assign rd_off  = rd_in_range ? offset_q[rd_ch] : '0;
    assign rd_gain = rd_in_range ? gain_q[rd_ch]   : UNITY;
    assign rd_err  = ~rd_in_range;

    always_comb begin
        offset_d = offset_q;
        gain_d   = gain_q;
        if (cfg_we && wr_in_range) begin
            if (cfg_sel) begin
                gain_d[cfg_ch] = cfg_wdata;
            end else begin
                offset_d[cfg_ch] = cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                offset_q[i] <= '0;
                gain_q[i]   <= UNITY;
            end
        end else begin
            offset_q <= offset_d;
            gain_q   <= gain_d;
        end
    end

endmodule

// File: rtl/multi_ch_cal_datapath.sv
// Multi-channel offset/gain calibration: res = sat(sat(a2d + offset[ch]) * gain[ch]).
// A four-state FSM snapshots coefficients on accept, then runs the add and multiply stages.
module multi_ch_cal_datapath
    import cal_pkg::*;
#(
    parameter int  DATA_W   = 12,
    parameter int  CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] a2d,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] res,
    output logic              out_sat,
    output logic              out_err
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a2d_q, a2d_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] coef_off_q, coef_off_d;
    logic [DATA_W-1:0] coef_gain_q, coef_gain_d;
    logic [DATA_W-1:0] tmp_q, tmp_d;
    logic              add_sat_q, add_sat_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_sat_q, out_sat_d;
    logic              out_err_q, out_err_d;

    logic [DATA_W-1:0] rf_off;
    logic [DATA_W-1:0] rf_gain;
    logic              rf_err;
    sat_res_t          add_r;
    sat_res_t          mul_r;

    cal_coef_rf #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_coef_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_ch    (cfg_ch),
        .cfg_wdata (cfg_wdata),
        .rd_ch     (in_ch),
        .rd_off    (rf_off),
        .rd_gain   (rf_gain),
        .rd_err    (rf_err)
    );

    assign add_r = sat_add_u(MAX_W'(a2d_q), MAX_W'(coef_off_q), DATA_W);
    assign mul_r = sat_mul_fx(MAX_W'(tmp_q), MAX_W'(coef_gain_q), DATA_W);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign res       = res_q;
    assign out_ch    = out_ch_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;

    // Upper helper bits are always zero for in-range widths; folding them into sat keeps any surprise visible.
    always_comb begin
        state_d     = state_q;
        a2d_d       = a2d_q;
        ch_d        = ch_q;
        coef_off_d  = coef_off_q;
        coef_gain_d = coef_gain_q;
        tmp_d       = tmp_q;
        add_sat_d   = add_sat_q;
        res_d       = res_q;
        out_ch_d    = out_ch_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = ADD;
                    a2d_d       = a2d;
                    ch_d        = in_ch;
                    coef_off_d  = rf_off;
                    coef_gain_d = rf_gain;
                    out_sat_d   = 1'b0;
                    out_err_d   = rf_err;
                end
            end
            ADD: begin
                tmp_d     = add_r.val[DATA_W-1:0];
                add_sat_d = add_r.sat | (|add_r.val[MAX_W-1:DATA_W]);
                state_d   = MUL;
            end
            MUL: begin
                res_d     = mul_r.val[DATA_W-1:0];
                out_sat_d = add_sat_q | mul_r.sat | (|mul_r.val[MAX_W-1:DATA_W]);
                out_ch_d  = ch_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a2d_q       <= '0;
            ch_q        <= '0;
            coef_off_q  <= '0;
            coef_gain_q <= '0;
            tmp_q       <= '0;
            add_sat_q   <= 1'b0;
            res_q       <= '0;
            out_ch_q    <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a2d_q       <= a2d_d;
            ch_q        <= ch_d;
            coef_off_q  <= coef_off_d;
            coef_gain_q <= coef_gain_d;
            tmp_q       <= tmp_d;
            add_sat_q   <= add_sat_d;
            res_q       <= res_d;
            out_ch_q    <= out_ch_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_multi_ch_cal_datapath.sv
// Randomised and directed bench for multi_ch_cal_datapath against an integer-arithmetic reference model.
// A second 3-channel instance covers the out-of-range channel path.
module tb_multi_ch_cal_datapath;

    localparam int MAXV  = 4095;
    localparam int UNITY = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_ch;
    logic [11:0] a2d;
    logic        cfg_we, cfg_sel;
    logic [1:0]  cfg_ch;
    logic [11:0] cfg_wdata;
    logic        out_valid, out_ready;
    logic [1:0]  out_ch;
    logic [11:0] res;
    logic        out_sat, out_err;

    logic        in_valid3, in_ready3;
    logic [1:0]  in_ch3;
    logic [11:0] a2d3;
    logic        cfg_we3, cfg_sel3;
    logic [1:0]  cfg_ch3;
    logic [11:0] cfg_wdata3;
    logic        out_valid3, out_ready3;
    logic [1:0]  out_ch3;
    logic [11:0] res3;
    logic        out_sat3, out_err3;

    int checks = 0;
    int errors = 0;
    int m_off  [4];
    int m_gain [4];
    int exp_res;
    int exp_sat;
    int exp_ch;

    always #5 clk = ~clk;

    multi_ch_cal_datapath dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_ch (in_ch), .a2d (a2d),
        .cfg_we (cfg_we), .cfg_sel (cfg_sel), .cfg_ch (cfg_ch), .cfg_wdata (cfg_wdata),
        .out_valid (out_valid), .out_ready (out_ready), .out_ch (out_ch), .res (res),
        .out_sat (out_sat), .out_err (out_err)
    );

    multi_ch_cal_datapath #(.DATA_W (12), .CHANNELS (3)) dut3 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid3), .in_ready (in_ready3), .in_ch (in_ch3), .a2d (a2d3),
        .cfg_we (cfg_we3), .cfg_sel (cfg_sel3), .cfg_ch (cfg_ch3), .cfg_wdata (cfg_wdata3),
        .out_valid (out_valid3), .out_ready (out_ready3), .out_ch (out_ch3), .res (res3),
        .out_sat (out_sat3), .out_err (out_err3)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_off[i]  = 0;
            m_gain[i] = UNITY;
        end
    endtask

    task automatic modelWrite(input bit sel, input int ch, input int data);
        if (sel) m_gain[ch] = data;
        else     m_off[ch]  = data;
    endtask

    // Reference: signed offset add with clamp, then real-valued gain product truncated and clamped.
    task automatic modelCalc(input int ch, input int sample, output int r, output int s);
        int     off;
        int     sum;
        longint prod;
        off = m_off[ch];
        if (off >= 2048) off = off - 4096;
        sum = sample + off;
        s   = 0;
        if (sum < 0) begin
            sum = 0;
            s   = 1;
        end else if (sum > MAXV) begin
            sum = MAXV;
            s   = 1;
        end
        prod = (longint'(sum) * longint'(m_gain[ch])) / 2048;
        if (prod > MAXV) begin
            prod = MAXV;
            s    = 1;
        end
        r = int'(prod);
    endtask

    task automatic cfgWrite(input bit sel, input int ch, input int data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_ch    = 2'(ch);
        cfg_wdata = 12'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        modelWrite(sel, ch, data);
    endtask

    // Accepts one sample (optionally with a same-cycle coefficient write) and checks the result in HOLD.
    task automatic applyStimulus(input int ch, input int sample, input bit wr_en, input bit wr_sel,
                                 input int wr_ch, input int wr_data, input int want_res, input int want_sat);
        int n;
        int lat;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_idle", int'(in_ready), 1);
        modelCalc(ch, sample, exp_res, exp_sat);
        exp_ch   = ch;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        a2d      = 12'(sample);
        if (wr_en) begin
            cfg_we    = 1'b1;
            cfg_sel   = wr_sel;
            cfg_ch    = 2'(wr_ch);
            cfg_wdata = 12'(wr_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (wr_en) modelWrite(wr_sel, wr_ch, wr_data);
        checkOutput("in_ready_busy", int'(in_ready), 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, 2);
        checkOutput("res", int'(res), exp_res);
        checkOutput("out_sat", int'(out_sat), exp_sat);
        checkOutput("out_ch", int'(out_ch), exp_ch);
        checkOutput("out_err", int'(out_err), 0);
        if (want_res >= 0) checkOutput("res_known", int'(res), want_res);
        if (want_sat >= 0) checkOutput("sat_known", int'(out_sat), want_sat);
    endtask

    // Stalls the consumer for a number of cycles (optionally rewriting a coefficient), then drains.
    task automatic releaseOutput(input int hold, input bit wr_en, input bit wr_sel, input int wr_ch, input int wr_data);
        for (int i = 0; i < hold; i++) begin
            if (i == 0 && wr_en) begin
                cfg_we    = 1'b1;
                cfg_sel   = wr_sel;
                cfg_ch    = 2'(wr_ch);
                cfg_wdata = 12'(wr_data);
            end
            @(negedge clk);
            if (i == 0 && wr_en) begin
                cfg_we = 1'b0;
                modelWrite(wr_sel, wr_ch, wr_data);
            end
            checkOutput("stall_out_valid", int'(out_valid), 1);
            checkOutput("stall_res", int'(res), exp_res);
            checkOutput("stall_out_ch", int'(out_ch), exp_ch);
            checkOutput("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("drain_out_valid", int'(out_valid), 0);
        checkOutput("drain_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int r_ch, r_a, r_wch, r_wd;
        bit r_we, r_sel;

        rst_n = 1'b0;
        in_valid = 1'b0; in_ch = '0; a2d = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_wdata = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_ch3 = '0; a2d3 = '0;
        cfg_we3 = 1'b0; cfg_sel3 = 1'b0; cfg_ch3 = '0; cfg_wdata3 = '0; out_ready3 = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_res", int'(res), 0);
        checkOutput("rst_out_ch", int'(out_ch), 0);
        checkOutput("rst_out_sat", int'(out_sat), 0);
        checkOutput("rst_out_err", int'(out_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed calibration cases");
        cfgWrite(1'b0, 0, 'hFFE);
        applyStimulus(0, 'h89A, 1'b0, 1'b0, 0, 0, 'h898, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        cfgWrite(1'b1, 0, 'hC00);
        applyStimulus(0, 'h89A, 1'b0, 1'b0, 0, 0, 'hCE4, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        cfgWrite(1'b1, 1, 'hC00);
        applyStimulus(1, 'hABC, 1'b0, 1'b0, 0, 0, 'hFFF, 1);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        cfgWrite(1'b0, 2, 'h555);
        applyStimulus(2, 'hABC, 1'b0, 1'b0, 0, 0, 'hFFF, 1);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        cfgWrite(1'b0, 3, 'hFFE);
        applyStimulus(3, 'h001, 1'b0, 1'b0, 0, 0, 'h000, 1);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        applyStimulus(3, 'h003, 1'b0, 1'b0, 0, 0, 'h001, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        cfgWrite(1'b0, 0, 'h555);
        cfgWrite(1'b1, 0, 'h600);
        applyStimulus(0, 'h456, 1'b0, 1'b0, 0, 0, 'h740, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);

        $display("[TB] back-pressure with coefficient rewrite");
        applyStimulus(2, 'h300, 1'b0, 1'b0, 0, 0, 'h855, 0);
        releaseOutput(5, 1'b1, 1'b1, 2, 'h400);
        applyStimulus(2, 'h300, 1'b0, 1'b0, 0, 0, 'h42A, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);

        $display("[TB] snapshot on accept");
        applyStimulus(1, 'h400, 1'b1, 1'b1, 1, 'h800, 'h600, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1, 'h400, 1'b0, 1'b0, 0, 0, 'h400, 0);
        releaseOutput(0, 1'b0, 1'b0, 0, 0);

        $display("[TB] randomised traffic");
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) != 0) begin
                cfgWrite($urandom_range(0, 1) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            end
            r_ch  = int'($urandom_range(0, 3));
            r_a   = int'($urandom_range(0, 4095));
            r_we  = ($urandom_range(0, 3) == 0);
            r_sel = ($urandom_range(0, 1) != 0);
            r_wch = int'($urandom_range(0, 3));
            r_wd  = int'($urandom_range(0, 4095));
            applyStimulus(r_ch, r_a, r_we, r_sel, r_wch, r_wd, -1, -1);
            releaseOutput(int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0);
        end

        $display("[TB] reset while in MUL");
        cfgWrite(1'b0, 0, 'h100);
        cfgWrite(1'b1, 3, 'h400);
        in_valid = 1'b1;
        in_ch    = 2'd0;
        a2d      = 12'h200;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_out_valid", int'(out_valid), 0);
        checkOutput("rst_mid_in_ready", int'(in_ready), 1);
        checkOutput("rst_mid_res", int'(res), 0);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        checkOutput("rst_mid_no_late_valid", int'(out_valid), 0);
        for (int c = 0; c < 4; c++) begin
            r_a = int'($urandom_range(0, 4095));
            applyStimulus(c, r_a, 1'b0, 1'b0, 0, 0, r_a, 0);
            releaseOutput(0, 1'b0, 1'b0, 0, 0);
        end

        $display("[TB] out-of-range channel on 3-channel instance");
        cfg_we3    = 1'b1;
        cfg_sel3   = 1'b1;
        cfg_ch3    = 2'd3;
        cfg_wdata3 = 12'h000;
        @(negedge clk);
        cfg_sel3   = 1'b0;
        cfg_wdata3 = 12'h100;
        @(negedge clk);
        cfg_we3   = 1'b0;
        in_valid3 = 1'b1;
        in_ch3    = 2'd3;
        a2d3      = 12'h345;
        @(negedge clk);
        in_valid3 = 1'b0;
        n = 0;
        while (out_valid3 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("oor_latency", n, 2);
        checkOutput("oor_res", int'(res3), 'h345);
        checkOutput("oor_out_err", int'(out_err3), 1);
        checkOutput("oor_out_sat", int'(out_sat3), 0);
        checkOutput("oor_out_ch", int'(out_ch3), 3);
        out_ready3 = 1'b1;
        @(negedge clk);
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        in_ch3     = 2'd2;
        a2d3       = 12'h9AB;
        @(negedge clk);
        in_valid3 = 1'b0;
        n = 0;
        while (out_valid3 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("inrange3_res", int'(res3), 'h9AB);
        checkOutput("inrange3_out_err", int'(out_err3), 0);
        checkOutput("inrange3_out_ch", int'(out_ch3), 2);
        out_ready3 = 1'b1;
        @(negedge clk);
        out_ready3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
